// File: rtl/aes_encrypt_128_iter_if.sv
// Handshake bundle for the iterative AES-128 encrypt core.
// The master offers plain/key blocks and consumes cipher/key10 results.
interface aes_encrypt_128_iter_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] plain;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] cipher;
   logic [127:0] key10;

   modport master (
      output in_valid, plain, key, out_ready,
      input  in_ready, out_valid, cipher, key10
   );

   modport slave (
      input  in_valid, plain, key, out_ready,
      output in_ready, out_valid, cipher, key10
   );
endinterface

// File: rtl/aes_encrypt_128_iter.sv
// Iterative AES-128 encryption: one round per clock with on-the-fly key expansion.
// Byte 0 of every 128-bit word sits at [127:120]; the state is column-major.
module aes_encrypt_128_iter (
   input  logic                         clk,
   input  logic                         rst,
   aes_encrypt_128_iter_if.slave        aes_if
);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

   localparam logic [0:255][7:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   fsm_t         fsm_q, fsm_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] state_q, state_d;
   logic [127:0] rkey_q, rkey_d;
   logic [127:0] sr_sb;
   logic [127:0] mixed;
   logic [127:0] nk;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[x];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
      return o;
   endfunction

   // Row r of column c takes the byte from column (c+r) mod 4 of the same row.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] rot, temp, w0, w1, w2, w3;
      rot  = {k[23:0], k[31:24]};
      temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
             ^ {rc, 24'h0};
      w0   = k[127:96] ^ temp;
      w1   = k[95:64]  ^ w0;
      w2   = k[63:32]  ^ w1;
      w3   = k[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   always_comb begin
      sr_sb = shift_rows(sub_bytes(state_q));
      mixed = mix_columns(sr_sb);
      nk    = expand(rkey_q, rcon(round_q));
   end

   always_comb begin
      fsm_d   = fsm_q;
      round_d = round_q;
      state_d = state_q;
      rkey_d  = rkey_q;
      case (fsm_q)
         IDLE: begin
            if (aes_if.in_valid) begin
               state_d = aes_if.plain ^ aes_if.key;
               rkey_d  = aes_if.key;
               round_d = 4'd1;
               fsm_d   = ROUND;
            end
         end
         ROUND: begin
            state_d = ((round_q == 4'd10) ? sr_sb : mixed) ^ nk;
            rkey_d  = nk;
            round_d = round_q + 4'd1;
            if (round_q == 4'd10) fsm_d = DONE;
         end
         DONE: begin
            if (aes_if.out_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q   <= IDLE;
         round_q <= 4'd0;
      end else begin
         fsm_q   <= fsm_d;
         round_q <= round_d;
      end
   end

   // Datapath registers are left unreset; the outputs are masked outside DONE instead.
   always_ff @(posedge clk) begin
      state_q <= state_d;
      rkey_q  <= rkey_d;
   end

   assign aes_if.in_ready  = (fsm_q == IDLE);
   assign aes_if.out_valid = (fsm_q == DONE);
   assign aes_if.cipher    = (fsm_q == DONE) ? state_q : 128'h0;
   assign aes_if.key10     = (fsm_q == DONE) ? rkey_q  : 128'h0;

endmodule

// File: tb/tb_aes_encrypt_128_iter.sv
// Directed bench for aes_encrypt_128_iter using FIPS-197 known-answer vectors.
module tb_aes_encrypt_128_iter;

   typedef struct {
      logic [127:0] plain;
      logic [127:0] key;
      logic [127:0] cipher;
      logic [127:0] key10;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[3];

   always #5 clk = ~clk;

   aes_encrypt_128_iter_if bus();

   aes_encrypt_128_iter dut (
      .clk    (clk),
      .rst    (rst),
      .aes_if (bus)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int w;
      w = 0;
      while (!bus.in_ready && w < 30) begin
         cyc();
         w++;
      end
      check({name, " in_ready"}, 128'(bus.in_ready), 128'd1);
   endtask

   // Accepts one block and waits for its result, checking latency and values.
   task automatic run_vec(input vec_t v, input string name);
      int lat;
      wait_ready(name);
      bus.plain    = v.plain;
      bus.key      = v.key;
      bus.in_valid = 1'b1;
      cyc();
      bus.in_valid = 1'b0;
      bus.plain    = ~v.plain;
      bus.key      = ~v.key;
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         cyc();
         lat++;
      end
      check({name, " latency"}, 128'(lat), 128'd11);
      check({name, " cipher"}, bus.cipher, v.cipher);
      check({name, " key10"}, bus.key10, v.key10);
   endtask

   task automatic release_out(input string name);
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
      check({name, " out_valid after ack"}, 128'(bus.out_valid), 128'd0);
      check({name, " in_ready after ack"}, 128'(bus.in_ready), 128'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, nacc, nout, seen;
      int acc_t[2];
      int out_t[2];
      logic [127:0] held;

      vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5};
      vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[2] = '{128'h0, 128'h0,
                  128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

      // Reset with in_valid asserted: reset must win, leaving the core idle.
      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.plain     = vecs[0].plain;
      bus.key       = vecs[0].key;
      bus.out_ready = 1'b0;
      cyc();
      cyc();
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      check("reset in_ready", 128'(bus.in_ready), 128'd1);
      check("reset out_valid", 128'(bus.out_valid), 128'd0);
      check("reset cipher", bus.cipher, 128'h0);
      check("reset key10", bus.key10, 128'h0);

      // Table-driven known-answer vectors.
      for (int i = 0; i < 3; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
         release_out($sformatf("vec%0d", i));
      end

      // Back-pressure on the all-zero vector with ignored in_valid pulses.
      run_vec(vecs[2], "hold");
      held = bus.cipher;
      for (int i = 0; i < 20; i++) begin
         bus.in_valid = i[0];
         bus.plain    = vecs[0].plain;
         bus.key      = vecs[0].key;
         cyc();
         check($sformatf("hold out_valid %0d", i), 128'(bus.out_valid), 128'd1);
         check($sformatf("hold cipher %0d", i), bus.cipher, held);
         check($sformatf("hold in_ready %0d", i), 128'(bus.in_ready), 128'd0);
      end
      bus.in_valid = 1'b0;
      check("hold key10", bus.key10, vecs[2].key10);
      release_out("hold");

      // Back-to-back with out_ready tied high.
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.plain     = vecs[0].plain;
      bus.key       = vecs[0].key;
      cnt = 0;
      nacc = 0;
      nout = 0;
      while (nout < 2 && cnt < 80) begin
         if (bus.out_valid) begin
            out_t[nout] = cnt;
            check($sformatf("b2b cipher %0d", nout), bus.cipher, vecs[nout].cipher);
            nout++;
         end
         if (bus.in_valid && bus.in_ready) begin
            acc_t[nacc] = cnt;
            nacc++;
            cyc();
            cnt++;
            if (nacc == 1) begin
               bus.plain = vecs[1].plain;
               bus.key   = vecs[1].key;
            end else begin
               bus.in_valid = 1'b0;
            end
         end else begin
            cyc();
            cnt++;
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("b2b outputs seen", 128'(nout), 128'd2);
      if (nout == 2 && nacc == 2) begin
         check("b2b accept spacing", 128'(acc_t[1] - acc_t[0]), 128'd12);
         check("b2b first valid", 128'(out_t[0] - acc_t[0]), 128'd11);
         check("b2b second valid", 128'(out_t[1] - acc_t[0]), 128'd23);
      end

      // Reset five cycles into an encryption discards the partial result.
      wait_ready("midrst");
      bus.plain    = vecs[0].plain;
      bus.key      = vecs[0].key;
      bus.in_valid = 1'b1;
      cyc();
      bus.in_valid = 1'b0;
      repeat (4) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("midrst in_ready", 128'(bus.in_ready), 128'd1);
      check("midrst out_valid", 128'(bus.out_valid), 128'd0);
      check("midrst cipher", bus.cipher, 128'h0);
      check("midrst key10", bus.key10, 128'h0);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         cyc();
         if (bus.out_valid) seen++;
      end
      check("midrst no output", 128'(seen), 128'd0);
      run_vec(vecs[0], "after_rst");
      release_out("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_encrypt_128_iter.md
# aes_encrypt_128_iter

Iterative AES-128 encryption core: one round per clock, with on-the-fly key expansion and valid/ready handshakes on both sides. It is the encrypt-direction counterpart of the combinational AES-128 decrypt datapath and follows the same FIPS-197 byte ordering, so a cipher produced here decrypts directly there. It also exports the final (round-10) round key, which is the starting key the decrypt side needs for its inverse schedule.

## Interface
- No parameters. Key size is fixed at 128 bits (Nr = 10).
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  plain/key pair offered
- in_ready  out  1  core can accept a block (high only in IDLE)
- plain  in  128  plaintext; byte 0 = [127:120], column-major state as FIPS-197
- key  in  128  cipher key, same byte order
- out_valid  out  1  cipher/key10 valid
- out_ready  in  1  consumer accepts result
- cipher  out  128  ciphertext
- key10  out  128  round-10 round key of the accepted key

## Operation
- Registers: state[127:0], rkey[127:0], round[3:0], FSM {IDLE, ROUND, DONE}.
- IDLE: in_ready=1. On in_valid && in_ready, the core captures the block:
  - state <= plain ^ key
  - rkey <= key
  - round <= 1
  - go to ROUND
- ROUND, each cycle:
  - nk = expand(rkey, rcon[round]), with rcon = 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
  - state <= AddRoundKey(ShiftRows(SubBytes(state)) followed by MixColumns, nk).
  - MixColumns is skipped when round==10.
  - rkey <= nk; round <= round+1.
  - After the round==10 update, go to DONE.
- expand: temp = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0'=w0^temp; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'. w0 is [127:96].
- SubBytes uses a combinational S-box. Implement it as a 256-entry case or function: 16 instances for the state plus 4 for the key path.
- MixColumns uses xtime over GF(2^8), polynomial 0x11b.
- DONE: out_valid=1, cipher=state, key10=rkey. Both outputs stay stable while out_valid && !out_ready. On out_ready, go to IDLE.
- in_valid and in_ready are ignored outside IDLE; plain and key are sampled only on the accept cycle.
- Rounds never stall. out_ready only gates the DONE→IDLE transition.

## Timing
- Reset values: in_ready=0 during the rst cycle, then 1 (IDLE); out_valid=0; cipher=0; key10=0; round=0.
- Accept in cycle t → ROUND during t+1..t+10 → out_valid=1 from t+11.
- Latency is 11 cycles accept-to-valid.
- If out_ready is already high at t+11, the handshake completes in t+11, in_ready=1 in t+12, and the next accept is possible at t+12. Throughput is 1 block per 12 cycles.
- Back-pressure: out_valid is held indefinitely with cipher and key10 unchanged; in_ready stays 0.
- rst mid-ROUND or mid-DONE: the next cycle is IDLE with outputs at reset values. The partial result is discarded and never presented.
- rst has priority over any simultaneous handshake.
- cipher and key10 are driven from registers only, with no combinational path from inputs to outputs.
- in_ready is a registered FSM decode, not dependent on in_valid.

## Test plan
- FIPS-197 C.1: plain=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f → cipher=69c4e0d86a7b0430d8cdb78070b4c55a and key10=13111d7fe3944a17f307a78b4d2b30c5, out_valid exactly 11 cycles after accept.
- FIPS-197 App. B: plain=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c → cipher=3925841d02dc09fbdc118597196a0b32, key10=d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero plain and key → cipher=66e94bd4ef8a2c3b884cfa59ca342b2e. Then hold out_ready=0 for 20 cycles: out_valid stays 1, cipher stable, in_ready=0, and in_valid pulses are ignored.
- Back-to-back: out_ready tied high, vectors C.1 then App. B offered continuously → accepts at t and t+12, correct ciphers at t+11 and t+23.
- Assert rst at t+5 mid-encryption → IDLE next cycle, out_valid never rises. A fresh C.1 accept then yields the correct cipher.
- Round-trip: feed cipher and key from the C.1 test into the decrypt datapath → plain=00112233445566778899aabbccddeeff.
